// File: rtl/inst_queue.sv
// inst_queue: dual-issue instruction queue between fetch and a decoder pair.
// Circular buffer of {pc, inst}, up to two pushes and two pops per cycle.
// Optional feature: define INST_QUEUE_BYPASS_EN to forward pushes straight
// to the read ports while the queue is empty.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     w_ena0,
  input  logic                     w_ena1,
  input  logic [31:0]              w_pc0,
  input  logic [31:0]              w_pc1,
  input  logic [31:0]              w_inst0,
  input  logic [31:0]              w_inst1,
  output logic                     w_ready,
  output logic                     r_valid0,
  output logic                     r_valid1,
  output logic [31:0]              r_pc0,
  output logic [31:0]              r_inst0,
  output logic [31:0]              r_pc1,
  output logic [31:0]              r_inst1,
  input  logic                     r_take0,
  input  logic                     r_take1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr_nx1;
  logic [PTR_W-1:0] wptr_nx1;

  logic             bypass_act;
  logic             take0;
  logic             take1;
  logic             push0;
  logic             push1;
  logic             wr0_en;
  logic             wr1_en;
  logic [31:0]      wr0_pc;
  logic [31:0]      wr0_inst;
  logic [1:0]       rd_adv;
  logic [1:0]       wr_adv;

  assign rptr_nx1 = rptr + PTR_W'(1);
  assign wptr_nx1 = wptr + PTR_W'(1);

  // Readiness depends only on registered occupancy, never on this cycle's traffic.
  assign w_ready = (count <= CNT_W'(DEPTH - 2));

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass_act = (count == '0) && !flush;
`else
  assign bypass_act = 1'b0;
`endif

  // Read port: stored head entries, or the incoming pushes while bypassing.
  always_comb begin
    r_valid0 = (count != '0);
    r_valid1 = (count > CNT_W'(1));
    r_pc0    = mem_pc[rptr];
    r_inst0  = mem_inst[rptr];
    r_pc1    = mem_pc[rptr_nx1];
    r_inst1  = mem_inst[rptr_nx1];
    if (bypass_act) begin
      r_valid0 = w_ena0;
      r_valid1 = w_ena0 & w_ena1;
      r_pc0    = w_pc0;
      r_inst0  = w_inst0;
      r_pc1    = w_pc1;
      r_inst1  = w_inst1;
    end
  end

  assign take0 = r_take0 & r_valid0;
  assign take1 = take0 & r_take1 & r_valid1;
  assign push0 = w_ena0 & w_ready;
  assign push1 = push0 & w_ena1;

  // Write selection: a bypassed entry that is consumed immediately is never stored.
  always_comb begin
    wr0_en   = push0;
    wr1_en   = push1;
    wr0_pc   = w_pc0;
    wr0_inst = w_inst0;
    rd_adv   = {1'b0, take0} + {1'b0, take1};
    if (bypass_act) begin
      rd_adv = 2'd0;
      if (take1) begin
        wr0_en = 1'b0;
        wr1_en = 1'b0;
      end else if (take0) begin
        wr0_en   = push1;
        wr0_pc   = w_pc1;
        wr0_inst = w_inst1;
        wr1_en   = 1'b0;
      end
    end
    wr_adv = {1'b0, wr0_en} + {1'b0, wr1_en};
  end

  // Storage array; contents survive reset and flush, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr0_en) begin
        mem_pc[wptr]   <= wr0_pc;
        mem_inst[wptr] <= wr0_inst;
      end
      if (wr1_en) begin
        mem_pc[wptr_nx1]   <= w_pc1;
        mem_inst[wptr_nx1] <= w_inst1;
      end
    end
  end

  // Pointer and occupancy state; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PTR_W'(rd_adv);
      wptr  <= wptr + PTR_W'(wr_adv);
      count <= count + CNT_W'(wr_adv) - CNT_W'(rd_adv);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8). Honours INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, w_ena0, w_ena1, r_take0, r_take1;
  logic [31:0] w_pc0, w_pc1, w_inst0, w_inst1;
  logic        w_ready, r_valid0, r_valid1;
  logic [31:0] r_pc0, r_inst0, r_pc1, r_inst1;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int n;
  logic [31:0] next_pc, exp_pc;

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .w_ena0(w_ena0), .w_ena1(w_ena1),
    .w_pc0(w_pc0), .w_pc1(w_pc1), .w_inst0(w_inst0), .w_inst1(w_inst1),
    .w_ready(w_ready), .r_valid0(r_valid0), .r_valid1(r_valid1),
    .r_pc0(r_pc0), .r_inst0(r_inst0), .r_pc1(r_pc1), .r_inst1(r_inst1),
    .r_take0(r_take0), .r_take1(r_take1), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hFFFF_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    w_ena0 = 0; w_ena1 = 0; r_take0 = 0; r_take1 = 0; flush = 0;
    w_pc0 = 0; w_pc1 = 0; w_inst0 = 0; w_inst1 = 0;
  endtask

  task automatic cyc(input logic e0, input logic e1,
                     input logic [31:0] p0, input logic [31:0] i0,
                     input logic [31:0] p1, input logic [31:0] i1,
                     input logic t0, input logic t1, input logic fl);
    w_ena0 = e0; w_ena1 = e1; w_pc0 = p0; w_inst0 = i0; w_pc1 = p1; w_inst1 = i1;
    r_take0 = t0; r_take1 = t1; flush = fl;
    @(posedge clk); #1;
    clear();
  endtask

  task automatic push2(input logic [31:0] pa, input logic [31:0] pb);
    cyc(1, 1, pa, ins(pa), pb, ins(pb), 0, 0, 0);
  endtask

  task automatic push1(input logic [31:0] pa);
    cyc(1, 0, pa, ins(pa), 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic take(input logic t1);
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, t1, 0);
  endtask

  initial begin
    clear();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid0", 32'(r_valid0), 32'd0);
    check("rst_valid1", 32'(r_valid1), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd1);

    // First dual push, visible one cycle later
    cyc(1, 1, 32'hBFC00000, 32'h24080001, 32'hBFC00004, 32'h24090002, 0, 0, 0);
    check("push_count", 32'(count), 32'd2);
    check("push_valid0", 32'(r_valid0), 32'd1);
    check("push_valid1", 32'(r_valid1), 32'd1);
    check("push_inst0", r_inst0, 32'h24080001);
    check("push_inst1", r_inst1, 32'h24090002);
    check("push_pc0", r_pc0, 32'hBFC00000);

    // Fill toward full
    push2(32'hBFC00008, 32'hBFC0000C);
    check("fill4_count", 32'(count), 32'd4);
    push2(32'hBFC00010, 32'hBFC00014);
    check("fill6_count", 32'(count), 32'd6);
    check("fill6_ready", 32'(w_ready), 32'd1);
    push1(32'hBFC00018);
    check("fill7_count", 32'(count), 32'd7);
    check("fill7_ready", 32'(w_ready), 32'd0);
    push2(32'hDEAD0000, 32'hDEAD0004);
    check("drop_count", 32'(count), 32'd7);
    check("drop_head0", r_pc0, 32'hBFC00000);
    check("drop_head1", r_pc1, 32'hBFC00004);

    // Dual push accepted at count=DEPTH-2
    take(0);
    check("pop1_count", 32'(count), 32'd6);
    check("pop1_head", r_pc0, 32'hBFC00004);
    push2(32'hBFC0001C, 32'hBFC00020);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(w_ready), 32'd0);

    // Drain to 3: heads G,H,I
    take(1);
    check("pop2a_count", 32'(count), 32'd6);
    check("pop2a_head", r_pc0, 32'hBFC0000C);
    take(1);
    check("pop2b_head", r_pc0, 32'hBFC00014);
    take(0);
    check("pop3_count", 32'(count), 32'd3);
    check("pop3_head0", r_pc0, 32'hBFC00018);
    check("pop3_head1", r_pc1, 32'hBFC0001C);

    // Simultaneous dual push and dual take
    cyc(1, 1, 32'hBFC00024, ins(32'hBFC00024), 32'hBFC00028, ins(32'hBFC00028), 1, 1, 0);
    check("pp_count", 32'(count), 32'd3);
    check("pp_head0", r_pc0, 32'hBFC00020);
    check("pp_inst0", r_inst0, ins(32'hBFC00020));
    check("pp_head1", r_pc1, 32'hBFC00024);

    // Flush beats push and pop
    push2(32'hBFC0002C, 32'hBFC00030);
    check("pre_flush_count", 32'(count), 32'd5);
    cyc(1, 0, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1, 0, 1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid0", 32'(r_valid0), 32'd0);
    check("flush_valid1", 32'(r_valid1), 32'd0);
    check("flush_ready", 32'(w_ready), 32'd1);
    check("flush_rptr", 32'(dut.rptr), 32'd0);
    check("flush_wptr", 32'(dut.wptr), 32'd0);
    cyc(1, 0, 32'h80000000, 32'h8C020000, 32'h0, 32'h0, 0, 0, 0);
    check("post_flush_count", 32'(count), 32'd1);
    check("one_valid0", 32'(r_valid0), 32'd1);
    check("one_valid1", 32'(r_valid1), 32'd0);
    check("post_flush_pc", r_pc0, 32'h80000000);
    check("post_flush_mem0", dut.mem_pc[0], 32'h80000000);

    // Take without matching valid
    take(1);
    check("overtake_count", 32'(count), 32'd0);
    take(0);
    check("empty_take_count", 32'(count), 32'd0);

    // Reset mid-operation, with push and pop in the same cycle
    push2(32'h00000100, 32'h00000104);
    check("pre_rst_count", 32'(count), 32'd2);
    rst = 1;
    cyc(1, 1, 32'h00000108, 32'h0, 32'h0000010C, 32'h0, 1, 0, 0);
    rst = 0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid0", 32'(r_valid0), 32'd0);
    check("mid_rst_ready", 32'(w_ready), 32'd1);

`ifdef INST_QUEUE_BYPASS_EN
    w_ena0 = 1; w_pc0 = 32'h00002000; w_inst0 = 32'h8C020000; r_take0 = 1;
    #1;
    check("byp_valid0", 32'(r_valid0), 32'd1);
    check("byp_inst0", r_inst0, 32'h8C020000);
    @(posedge clk); #1;
    clear();
    check("byp_count", 32'(count), 32'd0);
`else
    w_ena0 = 1; w_pc0 = 32'h00002000; w_inst0 = 32'h8C020000; r_take0 = 1;
    #1;
    check("nobyp_valid0", 32'(r_valid0), 32'd0);
    @(posedge clk); #1;
    clear();
    check("nobyp_count", 32'(count), 32'd1);
    check("nobyp_inst0", r_inst0, 32'h8C020000);
    take(0);
    check("nobyp_drain", 32'(count), 32'd0);
`endif

    // Wrap: alternating single/dual push and pop, PCs must stay sequential
    next_pc = 32'h00001000;
    exp_pc  = 32'h00001000;
    for (int i = 0; i < 20; i++) begin
      n = (i % 2 == 1) ? 2 : 1;
      w_ena0 = 1; w_pc0 = next_pc; w_inst0 = ins(next_pc);
      w_ena1 = (n == 2); w_pc1 = next_pc + 32'd4; w_inst1 = ins(next_pc + 32'd4);
      next_pc = next_pc + 32'(4 * n);
      #1;
      r_take0 = r_valid0;
      r_take1 = r_valid0 && r_valid1 && (n == 2);
      if (r_take0) begin
        check("wrap_pc0", r_pc0, exp_pc);
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      if (r_take1) begin
        check("wrap_pc1", r_pc1, exp_pc);
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      @(posedge clk); #1;
      clear();
    end
    for (int i = 0; i < 6; i++) begin
      if (r_valid0) begin
        r_take0 = 1;
        check("drain_pc0", r_pc0, exp_pc);
        exp_pc = exp_pc + 32'd4;
        popped++;
        @(posedge clk); #1;
        clear();
      end
    end
    check("wrap_popped", 32'(popped), 32'd30);
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_last_pc", exp_pc, next_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter: DEPTH, 8, number of entries; a power of two, minimum 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 flush  input  1  discard all entries (branch redirect or exception).
REQ-005 w_ena0 / w_ena1  input  1 each  push slot0 / slot1 from fetch; w_ena1 is asserted only with w_ena0.
REQ-006 w_pc0 / w_pc1  input  32 each  PC of each pushed instruction.
REQ-007 w_inst0 / w_inst1  input  32 each  instruction word of each pushed instruction.
REQ-008 w_ready  output  1  at least 2 free entries.
REQ-009 r_valid0 / r_valid1  output  1 each  head entry / head+1 entry present.
REQ-010 r_pc0, r_inst0, r_pc1, r_inst1  output  32 each  head and head+1 PC and instruction word, fed to the decoder pair.
REQ-011 r_take0 / r_take1  input  1 each  decoder consumes head / head+1; r_take1 is asserted only with r_take0.
REQ-012 count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-013 Storage: circular buffer of {pc, inst}; 3-bit read and write pointers for DEPTH=8, wrapping modulo DEPTH.
REQ-014 Push: w_ena0 & w_ready writes slot0 at wptr and slot1 at wptr+1; wptr advances by w_ena0+w_ena1.
REQ-015 Push with w_ready=0 is dropped; state is unchanged.
REQ-016 Pop: r_take0 advances rptr by 1; r_take0 & r_take1 advances it by 2.
REQ-017 r_take0 without r_valid0, or r_take1 without r_valid1, has no effect.
REQ-018 Ordering: slot0 is always older than slot1; output order equals push order.
REQ-019 Same-cycle push and pop: both apply; next count = count + pushes - pops.
REQ-020 Full boundary: with count=DEPTH-2 a dual push is accepted (w_ready=1); with count=DEPTH-1, w_ready=0.
REQ-021 Empty boundary: count=0 drives r_valid0=0 and r_valid1=0; count=1 drives r_valid0=1 and r_valid1=0.
REQ-022 r_pc and r_inst are don't-care when the matching r_valid is 0; the bench does not check them.
REQ-023 Flush has priority over push and pop in the same cycle: next cycle count=0, rptr=wptr=0, and that cycle's push is discarded.
REQ-024 Write-to-read latency is 1 cycle: a push at edge N is visible on r_* after edge N.
REQ-025 w_ready and count are registered-state functions only; neither depends combinationally on w_ena or r_take.

Reset
REQ-026 rst=1 at a rising edge sets rptr=0, wptr=0, count=0; then r_valid0=0, r_valid1=0, w_ready=1.
REQ-027 rst takes priority over flush, push and pop.
REQ-028 Reset mid-operation discards all entries; storage contents are not cleared.

Configuration
REQ-029 Macro INST_QUEUE_BYPASS_EN.
REQ-030 Defined: when count=0 and flush=0, r_valid0/1 follow w_ena0/1 and r_pc/r_inst follow w_pc/w_inst combinationally.
REQ-031 Defined: a bypassed instruction taken in the same cycle is not written.
REQ-032 Defined: a bypassed instruction not taken is written normally.
REQ-033 Defined: a partial take writes only slot1.
REQ-034 Undefined: no bypass; REQ-024 latency applies unconditionally.

Verification
REQ-035 Reset, then push (0xBFC00000, 0x24080001) and (0xBFC00004, 0x24090002) -> next cycle count=2, r_valid0=1, r_valid1=1, r_inst0=0x24080001, r_inst1=0x24090002.
REQ-036 Fill with dual pushes until w_ready=0 -> count=7 after a single push; a further push is dropped and count stays 7.
REQ-037 count=3, dual push plus dual take in the same cycle -> count=3; new head is the third original entry.
REQ-038 count=5, flush together with a push and r_take0 -> next cycle count=0, r_valid0=0; the following push appears at pointer 0.
REQ-039 Wrap: 20 cycles of alternating single and dual push/pop -> output PC sequence is strictly sequential by 4, with no loss or duplication.
REQ-040 With INST_QUEUE_BYPASS_EN, empty queue, push of 0x8C020000 with r_take0=1 in the same cycle -> r_valid0=1 in that cycle and count=0 afterwards.
